// File: rtl/player_pos_tracker.sv
// Multi-player circular-track position tracker.
// Moves one player a tile per clock, jumping occupied tiles.
module player_pos_tracker #(
  parameter int MAX_PLAYERS = 4,
  parameter int BOARD_SIZE  = 24,
  parameter int POS_W       = 5,
  parameter int STEP_W      = 3,
  parameter int LAP_W       = 4,
  parameter int ID_W        = 2
) (
  input  logic                         B,
  input  logic                         rst,
  input  logic [ID_W:0]                n_players,
  input  logic                         start,
  input  logic [ID_W-1:0]              player_sel,
  input  logic [STEP_W-1:0]            steps,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [ID_W-1:0]              passed_id,
  output logic [MAX_PLAYERS*POS_W-1:0] pos_flat,
  output logic [MAX_PLAYERS*LAP_W-1:0] laps_flat
);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } state_t;

  typedef logic [MAX_PLAYERS-1:0][POS_W-1:0] pos_vec_t;
  typedef logic [MAX_PLAYERS-1:0][LAP_W-1:0] lap_vec_t;

  localparam logic [ID_W:0]    MAXN    = (ID_W+1)'(MAX_PLAYERS);
  localparam logic [ID_W:0]    MINN    = (ID_W+1)'(2);
  localparam logic [POS_W-1:0] LAST    = POS_W'(BOARD_SIZE - 1);
  localparam logic [LAP_W-1:0] LAP_MAX = '1;

  state_t            state_q, state_d;
  logic [ID_W:0]     n_act_q;
  logic [ID_W-1:0]   mover_q, mover_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  pos_vec_t          pos_q, pos_d;
  lap_vec_t          laps_q, laps_d;
  logic              pass_q, pass_d;
  logic [ID_W-1:0]   pid_q, pid_d;

  logic [ID_W:0]     n_clamp;
  pos_vec_t          rst_pos;
  logic [POS_W-1:0]  cur;
  logic [POS_W-1:0]  tgt;
  logic              occ;
  logic [ID_W-1:0]   occ_id;

  // Clamp the requested player count into the supported range.
  always_comb begin
    n_clamp = n_players;
    if (n_players < MINN) begin
      n_clamp = MINN;
    end else if (n_players > MAXN) begin
      n_clamp = MAXN;
    end
  end

  // Start tiles: constant per-count tables, evenly spaced.
  always_comb begin
    rst_pos = '0;
    for (int n = 2; n <= MAX_PLAYERS; n++) begin
      if (n_clamp == (ID_W+1)'(n)) begin
        for (int i = 0; i < n; i++) begin
          rst_pos[i] = POS_W'((i * BOARD_SIZE) / n);
        end
      end
    end
  end

  // Next tile for the mover and whether another player sits there.
  always_comb begin
    cur    = pos_q[mover_q];
    tgt    = (cur == LAST) ? '0 : cur + 1'b1;
    occ    = 1'b0;
    occ_id = '0;
    for (int j = 0; j < MAX_PLAYERS; j++) begin
      if (((ID_W+1)'(j) < n_act_q) &&
          (ID_W'(j) != mover_q) &&
          (pos_q[j] == tgt)) begin
        occ    = 1'b1;
        occ_id = ID_W'(j);
      end
    end
  end

  // Move FSM: next state and next board contents.
  always_comb begin
    state_d = state_q;
    mover_d = mover_q;
    rem_d   = rem_q;
    pos_d   = pos_q;
    laps_d  = laps_q;
    pass_d  = 1'b0;
    pid_d   = pid_q;
    unique case (state_q)
      IDLE: begin
        if (start &&
            ({1'b0, player_sel} < n_act_q)) begin
          mover_d = player_sel;
          rem_d   = steps;
          state_d = (steps == '0) ? DONE : STEP;
        end
      end
      STEP: begin
        pos_d[mover_q] = tgt;
        if ((tgt == '0) &&
            (laps_q[mover_q] != LAP_MAX)) begin
          laps_d[mover_q] = laps_q[mover_q] + 1'b1;
        end
        if (occ) begin
          pass_d = 1'b1;
          pid_d  = occ_id;
        end else begin
          rem_d = rem_q - 1'b1;
          if (rem_q == STEP_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset to start tiles.
  always_ff @(posedge B) begin
    if (rst) begin
      state_q <= IDLE;
      n_act_q <= n_clamp;
      mover_q <= '0;
      rem_q   <= '0;
      pos_q   <= rst_pos;
      laps_q  <= '0;
      pass_q  <= 1'b0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      mover_q <= mover_d;
      rem_q   <= rem_d;
      pos_q   <= pos_d;
      laps_q  <= laps_d;
      pass_q  <= pass_d;
      pid_q   <= pid_d;
    end
  end

  assign busy      = (state_q == STEP);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign passed_id = pid_q;
  assign pos_flat  = pos_q;
  assign laps_flat = laps_q;

endmodule

// File: tb/tb_player_pos_tracker.sv
// Bench for player_pos_tracker: random moves vs. a
// tile-walking reference model with a scoreboard monitor.
module tb_player_pos_tracker;

  localparam int MP = 4;
  localparam int BS = 24;
  localparam int PW = 5;
  localparam int SW = 3;
  localparam int LW = 4;
  localparam int IW = 2;

  logic              B = 1'b0;
  logic              rst;
  logic [IW:0]       n_players;
  logic              start;
  logic [IW-1:0]     player_sel;
  logic [SW-1:0]     steps;
  logic              busy;
  logic              done;
  logic              pass;
  logic [IW-1:0]     passed_id;
  logic [MP*PW-1:0]  pos_flat;
  logic [MP*LW-1:0]  laps_flat;

  player_pos_tracker #(
    .MAX_PLAYERS(MP), .BOARD_SIZE(BS), .POS_W(PW),
    .STEP_W(SW), .LAP_W(LW), .ID_W(IW)
  ) dut (
    .B(B), .rst(rst), .n_players(n_players),
    .start(start), .player_sel(player_sel),
    .steps(steps), .busy(busy), .done(done),
    .pass(pass), .passed_id(passed_id),
    .pos_flat(pos_flat), .laps_flat(laps_flat)
  );

  always #5 B = ~B;

  int cyc = 0;
  always @(posedge B) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [MP*PW-1:0] pos;
    logic [MP*LW-1:0] laps;
    int               dcyc;
  } exp_t;

  exp_t exp_q[$];
  int   pass_q[$];

  int m_n;
  int mpos[MP];
  int mlaps[MP];

  task automatic chk(string name, longint act, longint expv);
    n_cmp++;
    if (act != expv) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [MP*PW-1:0] m_pos();
    logic [MP*PW-1:0] v;
    for (int i = 0; i < MP; i++) v[i*PW +: PW] = PW'(mpos[i]);
    return v;
  endfunction

  function automatic logic [MP*LW-1:0] m_laps();
    logic [MP*LW-1:0] v;
    for (int i = 0; i < MP; i++) v[i*LW +: LW] = LW'(mlaps[i]);
    return v;
  endfunction

  function automatic bit m_occupied(int p, int t, output int id);
    id = 0;
    for (int j = 0; j < m_n; j++)
      if (j != p && mpos[j] == t) begin
        id = j;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  // Walks the mover tile by tile; returns number of skips.
  function automatic int m_move(int p, int k);
    int rem = k;
    int s = 0;
    int id;
    while (rem > 0) begin
      mpos[p] = (mpos[p] + 1) % BS;
      if (mpos[p] == 0 && mlaps[p] < (1 << LW) - 1)
        mlaps[p]++;
      if (m_occupied(p, mpos[p], id)) begin
        pass_q.push_back(id);
        s++;
      end else begin
        rem--;
      end
    end
    return s;
  endfunction

  // Monitor: pops expectations on each pass and done pulse.
  always @(negedge B) begin
    if (!rst) begin
      if (pass) begin
        if (pass_q.size() == 0) begin
          chk("unexpected_pass", 1, 0);
        end else begin
          chk("passed_id", passed_id, pass_q.pop_front());
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.dcyc);
          chk("done_pos", pos_flat, e.pos);
          chk("done_laps", laps_flat, e.laps);
          chk("done_busy", busy, 0);
          chk("pending_pass", pass_q.size(), 0);
        end
      end
    end
  end

  task automatic do_reset(int n);
    @(negedge B);
    rst = 1'b1;
    n_players = (IW+1)'(n);
    start = 1'b0;
    @(negedge B);
    rst = 1'b0;
    m_n = (n < 2) ? 2 : (n > MP) ? MP : n;
    for (int i = 0; i < MP; i++) begin
      mpos[i]  = (i < m_n) ? (i * BS) / m_n : 0;
      mlaps[i] = 0;
    end
    exp_q.delete();
    pass_q.delete();
    chk("rst_pos", pos_flat, m_pos());
    chk("rst_laps", laps_flat, 0);
    chk("rst_flags", {busy, done, pass}, 0);
    chk("rst_pid", passed_id, 0);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy || done) && w < 100) begin
      @(negedge B);
      w++;
    end
    if (w >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_move(int p, int k, bit inject);
    int   s;
    int   w;
    exp_t e;
    wait_idle();
    player_sel = IW'(p);
    steps = SW'(k);
    start = 1'b1;
    s = m_move(p, k);
    e.pos  = m_pos();
    e.laps = m_laps();
    e.dcyc = cyc + 1 + k + s;
    exp_q.push_back(e);
    @(negedge B);
    start = 1'b0;
    if (inject && busy) begin
      start = 1'b1;
      player_sel = IW'((p + 1) % m_n);
      steps = SW'(7);
      @(negedge B);
      start = 1'b0;
    end
    w = 0;
    while (!done && w < 200) begin
      @(negedge B);
      w++;
    end
    if (w >= 200) begin
      chk("done_timeout", 1, 0);
      exp_q.delete();
      pass_q.delete();
    end else if (inject) begin
      start = 1'b1;
      player_sel = IW'((p + 1) % m_n);
      steps = SW'(3);
      @(negedge B);
      start = 1'b0;
      chk("start_in_done_busy", busy, 0);
    end
  endtask

  task automatic illegal_start(int p);
    wait_idle();
    player_sel = IW'(p);
    steps = SW'(4);
    start = 1'b1;
    @(negedge B);
    start = 1'b0;
    chk("illegal_busy", {busy, done}, 0);
    chk("illegal_pos", pos_flat, m_pos());
  endtask

  initial begin
    logic [MP*PW-1:0] p4;
    int n;
    rst = 1'b1;
    n_players = 3'd4;
    start = 1'b0;
    player_sel = '0;
    steps = '0;

    do_reset(3);
    chk("rst3_const", pos_flat, {5'd0, 5'd16, 5'd8, 5'd0});
    do_reset(1);
    chk("rst1_const", pos_flat, {5'd0, 5'd0, 5'd12, 5'd0});

    do_reset(4);
    do_move(0, 5, 1'b0);
    chk("p0_at5", pos_flat[0 +: PW], 5);
    do_reset(4);
    do_move(0, 4, 1'b0);
    do_move(0, 3, 1'b0);
    chk("p0_at8", pos_flat[0 +: PW], 8);

    do_reset(2);
    do_move(1, 7, 1'b0);
    do_move(1, 3, 1'b0);
    do_move(1, 4, 1'b0);
    chk("p1_at3", pos_flat[PW +: PW], 3);
    chk("p1_lap", laps_flat[LW +: LW], 1);
    do_move(0, 0, 1'b1);
    do_move(1, 2, 1'b1);
    illegal_start(3);
    illegal_start(2);

    do_reset(4);
    wait_idle();
    player_sel = 2'd0;
    steps = 3'd5;
    start = 1'b1;
    @(negedge B);
    start = 1'b0;
    @(negedge B);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    n_players = 3'd4;
    @(negedge B);
    chk("abort_busy", busy, 0);
    p4 = {5'd18, 5'd12, 5'd6, 5'd0};
    chk("abort_pos", pos_flat, p4);
    rst = 1'b0;
    do_move(0, 5, 1'b0);
    chk("after_abort", pos_flat[0 +: PW], 5);

    for (int r = 0; r < 5; r++) begin
      n = (r == 4) ? 7 : r + 1;
      do_reset(n);
      for (int t = 0; t < 25; t++) begin
        do_move($urandom_range(0, m_n - 1),
                $urandom_range(0, 7),
                1'($urandom_range(0, 1)));
        if (m_n < MP && $urandom_range(0, 3) == 0)
          illegal_start($urandom_range(m_n, MP - 1));
      end
      wait_idle();
      chk("rand_pos", pos_flat, m_pos());
      chk("rand_laps", laps_flat, m_laps());
    end

    repeat (3) @(negedge B);
    chk("exp_left", exp_q.size(), 0);
    chk("pass_left", pass_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/player_pos_tracker.md
# player_pos_tracker

Parametrised board-position tracker for 2..MAX_PLAYERS players on a circular track of BOARD_SIZE tiles. It holds every player's tile and lap count, and moves one selected player forward by a requested step count, one tile per clock. Tiles occupied by other players are jumped over, and each jump is reported. It sits between the card/match logic, which issues moves, and the display/scoring logic, which reads positions and pass events. It replaces the single-player fixed-24-tile counter.

## Interface
Parameters:
- MAX_PLAYERS, 4: number of player slots implemented (2..8).
- BOARD_SIZE, 24: tiles on the track; positions are 0..BOARD_SIZE-1.
- POS_W, 5: position width; must satisfy 2^POS_W >= BOARD_SIZE.
- STEP_W, 3: width of the steps request.
- LAP_W, 4: per-player lap counter width.
- ID_W, 2: player index width; must satisfy 2^ID_W >= MAX_PLAYERS.

Ports:
- B, input, 1: clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- n_players, input, ID_W+1: active player count; sampled only while rst=1.
- start, input, 1: move request; one-cycle pulse.
- player_sel, input, ID_W: player to move.
- steps, input, STEP_W: number of tiles to advance.
- busy, output, 1: move in progress.
- done, output, 1: one-cycle pulse at move completion.
- pass, output, 1: one-cycle pulse when the mover jumps an occupied tile.
- passed_id, output, ID_W: index of the jumped player; valid while pass=1.
- pos_flat, output, MAX_PLAYERS*POS_W: player i position at bits [i*POS_W +: POS_W].
- laps_flat, output, MAX_PLAYERS*LAP_W: player i lap count, same packing.

## Operation
- Active count n_act is registered on reset as n_players clamped to [2, MAX_PLAYERS]. It holds until the next reset.
- Reset values:
  - Player i < n_act: position floor(i*BOARD_SIZE/n_act). For BOARD_SIZE=24 this gives n=2: 0,12; n=3: 0,8,16; n=4: 0,6,12,18.
  - Inactive slots: position 0.
  - All laps 0.
  - busy=0, done=0, pass=0, passed_id=0.
  - FSM in IDLE.
- Start positions come from constant per-n tables built at elaboration. No runtime divider.
- FSM states are IDLE, STEP and DONE.
- IDLE:
  - start=1 with player_sel < n_act latches the mover and rem=steps.
  - Goes to DONE if steps==0, otherwise to STEP.
  - start with player_sel >= n_act is ignored.
- STEP, evaluated once per cycle:
  - tgt = pos+1, or 0 if pos==BOARD_SIZE-1.
  - The mover always moves to tgt.
  - Moving to 0 increments the mover's laps, saturating at 2^LAP_W-1.
  - If tgt is occupied by another active player: pass=1 and passed_id = that player's index; rem is unchanged (a skip costs no step).
  - Otherwise rem decrements. When rem reaches 0, go to DONE with the mover on an unoccupied tile.
  - During a skip the mover briefly shares a tile only inside the cycle. The registered output never shows two active players on one tile after DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- start while busy=1 or in DONE is ignored; it is not queued.
- Only the mover's position and laps change during a move.
- Inactive slots are never movers and never count as occupants.
- rst=1 in any state aborts the move and restores every reset value on the next edge. Positions go back to start tiles.

## Timing
- Start sampled at edge t:
  - busy=1 from t+1 through the last STEP cycle.
  - done=1 in the cycle after the final STEP, with busy=0.
  - FSM returns to IDLE one cycle after done.
- Latency: a move of k steps with s skips has k+s STEP cycles. done asserts k+s+1 cycles after start, or 1 cycle after start when k=0.
- The earliest accepted next start is in the cycle after done.
- pos_flat, laps_flat and pass are registered; each updates at the edge closing the STEP cycle.
- Worst-case skips per move: n_act-1 per traversal of the occupied run.

## Test plan
- Reset with n_players=3 (BOARD_SIZE=24) -> pos 0,8,16, slot3=0, laps 0; n_players=1 reset -> clamped to 2, pos 0,12.
- n=4 reset, start player 0 steps=5 -> 5 STEP cycles, pos0=5, done at cycle 6, no pass.
- n=4, player 0 at 4, start steps=3 -> tile 6 occupied by player 1: pass=1 with passed_id=1 once, 4 STEP cycles, final pos0=8.
- n=2, player 1 at 22, steps=4 -> wraps to 2, laps1=1; with player 0 at tile 0 -> one pass (id 0), final pos1=3.
- steps=0 -> done one cycle after start, no position change; start during busy and start with player_sel=3 when n=2 -> ignored, no state change.
- rst asserted in mid-STEP with n_players=4 -> next cycle busy=0 and positions 0,6,12,18; a subsequent move behaves normally.
